// File: rtl/vdc_pkg.sv
// Shared VDC definitions: register indices, address-step select, step values,
// fetch starvation limit and the address-step helper.
package vdc_pkg;

  typedef enum logic [4:0] {
    REG_MAWR = 5'd0,
    REG_MARR = 5'd1,
    REG_VWR  = 5'd2
  } reg_idx_e;

  typedef enum logic [1:0] {
    INC_1   = 2'b00,
    INC_32  = 2'b01,
    INC_64  = 2'b10,
    INC_128 = 2'b11
  } inc_sel_e;

  localparam logic [15:0] STEP_1   = 16'd1;
  localparam logic [15:0] STEP_32  = 16'd32;
  localparam logic [15:0] STEP_64  = 16'd64;
  localparam logic [15:0] STEP_128 = 16'd128;

  localparam logic [2:0] STARVE_LIMIT = 3'd4;

  // 16-bit add wraps naturally: 0xFFFF + 1 = 0x0000.
  function automatic logic [15:0] step_addr(input logic [15:0] addr, input inc_sel_e sel);
    logic [15:0] step;
    case (sel)
      INC_1:   step = STEP_1;
      INC_32:  step = STEP_32;
      INC_64:  step = STEP_64;
      default: step = STEP_128;
    endcase
    return addr + step;
  endfunction

endpackage

// File: rtl/vram_port_arbiter.sv
// Single VRAM port shared between the display fetch engine and CPU register
// access. Optional VRAM_ADDR_MASK_EN limits MA to a 32K-word VRAM.
module vram_port_arbiter
  import vdc_pkg::*;
(
  input  logic        clock,
  input  logic        reset_N,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [4:0]  reg_idx,
  input  logic        hi_byte,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        busy,
  input  logic [1:0]  inc_sel,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic        fetch_ack,
  output logic        fetch_valid,
  output logic [15:0] fetch_data,
  output logic [15:0] MA,
  output logic        re,
  output logic        we,
  output logic [15:0] MD_in,
  input  logic [15:0] MD_out
);

  logic [15:0] mawr, marr, rd_buf, wr_data, ma_raw;
  logic [7:0]  vwr_lo;
  logic        wr_pending, rd_pending, rd_inflight;
  logic [2:0]  starve_cnt;
  logic        sel_mawr, sel_marr, sel_vwr;
  logic        cpu_ready, starving, grant_fetch, grant_wr, grant_rd;
  inc_sel_e    inc;

  assign inc      = inc_sel_e'(inc_sel);
  assign sel_mawr = (reg_idx == REG_MAWR);
  assign sel_marr = (reg_idx == REG_MARR);
  assign sel_vwr  = (reg_idx == REG_VWR);

  // A read already on the bus is not re-issued while its data returns.
  assign cpu_ready   = wr_pending | (rd_pending & ~rd_inflight);
  assign starving    = cpu_ready && (starve_cnt >= STARVE_LIMIT);
  assign grant_fetch = fetch_req & ~starving;
  assign grant_wr    = ~grant_fetch & wr_pending;
  assign grant_rd    = ~grant_fetch & ~wr_pending & rd_pending & ~rd_inflight;

  always_comb begin
    ma_raw = '0;
    if (grant_fetch)   ma_raw = fetch_addr;
    else if (grant_wr) ma_raw = mawr;
    else if (grant_rd) ma_raw = marr;
  end

`ifdef VRAM_ADDR_MASK_EN
  assign MA = ma_raw & 16'h7FFF;
`else
  assign MA = ma_raw;
`endif

  assign re         = grant_fetch | grant_rd;
  assign we         = grant_wr;
  assign MD_in      = grant_wr ? wr_data : '0;
  assign fetch_ack  = grant_fetch;
  assign fetch_data = fetch_valid ? MD_out : '0;
  assign busy       = wr_pending | rd_pending;

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      mawr        <= '0;
      marr        <= '0;
      rd_buf      <= '0;
      vwr_lo      <= '0;
      wr_data     <= '0;
      wr_pending  <= 1'b0;
      rd_pending  <= 1'b0;
      rd_inflight <= 1'b0;
      starve_cnt  <= '0;
      fetch_valid <= 1'b0;
      cpu_dout    <= '0;
    end else begin
      // CPU load of an address register wins over a same-cycle increment.
      if (reg_wr && sel_mawr) begin
        if (hi_byte) mawr[15:8] <= cpu_din;
        else         mawr[7:0]  <= cpu_din;
      end else if (grant_wr) begin
        mawr <= step_addr(mawr, inc);
      end

      if (reg_wr && sel_marr) begin
        if (hi_byte) marr[15:8] <= cpu_din;
        else         marr[7:0]  <= cpu_din;
      end else if (reg_rd && sel_vwr && hi_byte) begin
        marr <= step_addr(marr, inc);
      end

      if (reg_wr && sel_vwr && !hi_byte) vwr_lo <= cpu_din;

      if (reg_wr && sel_vwr && hi_byte) begin
        wr_data    <= {cpu_din, vwr_lo};
        wr_pending <= 1'b1;
      end else if (grant_wr) begin
        wr_pending <= 1'b0;
      end

      rd_inflight <= grant_rd;
      if (rd_inflight) rd_buf <= MD_out;

      if ((reg_wr && sel_marr && hi_byte) || (reg_rd && sel_vwr && hi_byte))
        rd_pending <= 1'b1;
      else if (rd_inflight)
        rd_pending <= 1'b0;

      if (!cpu_ready || grant_wr || grant_rd) starve_cnt <= '0;
      else if (grant_fetch)                   starve_cnt <= starve_cnt + 3'd1;

      fetch_valid <= grant_fetch;

      if (reg_rd) cpu_dout <= sel_vwr ? (hi_byte ? rd_buf[15:8] : rd_buf[7:0]) : 8'h00;
    end
  end

endmodule
